wb_stage_ctrl: RTL
==================

Name: wb_stage_ctrl

Overview:
Registered writeback stage for the RV32I pipeline, replacing the combinational result select. It accepts retiring instructions from MEM over a valid/ready handshake and selects the writeback result. For loads it waits for a variable-latency data-memory response, then extracts and sign- or zero-extends the sub-word. It drives the register-file write port and supports flush and load timeout.

Parameters:
XLEN, 32, datapath width; load extraction is defined for 32 only.
SRC_W, 2, width of the result-source select.
TIMEOUT, 64, cycles in WAIT_LOAD before the load is abandoned; range 2..1023.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
m_valid_i  in  1  MEM stage presents an instruction
m_ready_o  out  1  stage can accept; combinational, equals (state==IDLE)
m_reg_write_i  in  1  instruction writes rd
m_rd_i  in  5  destination register
m_result_src_i  in  SRC_W  0=ALU, 1=load, 2=PC+4, 3=immediate
m_alu_result_i  in  XLEN  ALU result; bits [1:0] give the load byte offset
m_pc_plus4_i  in  XLEN  PC+4
m_imm_i  in  XLEN  U-type immediate
m_funct3_i  in  3  load size/sign
mem_rvalid_i  in  1  load data valid (single-cycle pulse)
mem_rdata_i  in  XLEN  aligned load word
flush_i  in  1  kill the current and pending instruction
rf_we_o  out  1  register-file write enable, registered
rf_rd_o  out  5  write address, registered
rf_wdata_o  out  XLEN  write data, registered
load_timeout_o  out  1  one-cycle pulse when a load is abandoned
err_o  out  1  one-cycle pulse: illegal funct3, or unexpected rvalid in IDLE

Behaviour:
- Reset, asynchronous: state=IDLE, all rf_* outputs 0, timeout counter 0, load_timeout_o=0, err_o=0.
- FSM states:
  - IDLE: accept when m_valid_i && m_ready_o && !flush_i.
    - Non-load: rf_we_o = m_reg_write_i && (m_rd_i != 0), asserted in cycle N+1 for exactly 1 cycle.
    - rf_wdata_o in that cycle: src 0 = ALU result, 2 = PC+4, 3 = immediate.
    - Load (src 1): latch rd, reg_write, funct3 and offset; go to WAIT_LOAD; counter cleared.
  - WAIT_LOAD: m_ready_o=0; counter increments each cycle.
    - mem_rvalid_i in cycle M: rf write in cycle M+1 with extracted data; state IDLE from M+1, so a new accept is possible in M+1.
    - Counter reaching TIMEOUT-1 without rvalid: load_timeout_o pulses, no write, go to DRAIN.
  - DRAIN: m_ready_o=0; discard the next mem_rvalid_i, then go to IDLE.
- Load extraction, by funct3, on word >> (8*offset):
  - 000 = LB, sign-extend byte.
  - 001 = LH, sign-extend half.
  - 010 = LW, full word.
  - 100 = LBU, zero-extend byte.
  - 101 = LHU, zero-extend half.
  - Any other funct3: treat as LW and pulse err_o in the write cycle.
  - LH/LHU with offset 3 uses bits [31:24] of the word for the low byte; the upper byte is 0 before extension. Misalignment is upstream's responsibility.
- Flush:
  - flush_i in IDLE blocks acceptance in the same cycle.
  - flush_i in WAIT_LOAD: go to DRAIN; the write is cancelled.
  - flush_i in the same cycle as mem_rvalid_i: write cancelled, go to IDLE, since the response is already consumed.
  - flush_i in DRAIN: no effect.
  - flush_i never clears an already-registered rf_we_o.
- mem_rvalid_i in IDLE is ignored and pulses err_o.
- The write to x0 is suppressed, but the load handshake still completes.
- Reset mid-load returns to IDLE. Any in-flight memory response after reset is the memory's responsibility.

Decomposition:
- Package wb_pkg:
  - result_src_e enum: SRC_ALU=0, SRC_LOAD=1, SRC_PC4=2, SRC_IMM=3.
  - funct3 load constants.
  - wb_state_e enum: IDLE, WAIT_LOAD, DRAIN.
- One sub-module, load_extend: combinational funct3 + offset + word -> extended data and an illegal flag.

Test Plan:
- ALU op, rd=5, ALU=0x1234, accepted in cycle 10 -> cycle 11: rf_we_o=1, rf_rd_o=5, rf_wdata_o=0x1234; cycle 12: rf_we_o=0.
- LB, offset 2, rvalid 3 cycles after accept with word 0x00800000 -> next cycle rf_wdata_o=0xFFFFFF80. LHU with the same word at offset 2 -> 0x0080. m_ready_o stays low during the wait.
- Back-to-back PC+4 (0x104) and IMM (0xABCD0000) accepted in consecutive cycles -> two consecutive writes with those values. rd=0 -> no rf_we_o.
- Load, no rvalid for 64 cycles -> load_timeout_o pulses once, no write. A later rvalid is discarded in DRAIN, then m_ready_o returns to 1.
- flush_i during WAIT_LOAD, then rvalid with 0xDEADBEEF -> no write; m_ready_o is 1 the cycle after the rvalid.
- rst_n low for 1 cycle mid-WAIT_LOAD -> rf_we_o=0 and m_ready_o=1 immediately. funct3=011 -> LW data and an err_o pulse.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the writeback stage.
package wb_pkg;
  typedef enum logic [1:0] {
    SRC_ALU  = 2'd0,
    SRC_LOAD = 2'd1,
    SRC_PC4  = 2'd2,
    SRC_IMM  = 2'd3
  } result_src_e;
  typedef enum logic [1:0] {IDLE, WAIT_LOAD, DRAIN} wb_state_e;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/wb_stage_ctrl_load_extend.sv
// load_extend: shifts the loaded word by the byte offset and sign/zero-extends per funct3.
module load_extend
  import wb_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] data,
  output logic        illegal
);
  logic [31:0] s;
  assign s = word >> {offset, 3'b000};
  always_comb begin
    illegal = !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    data = funct3 == F3_LB  ? {{24{s[7]}}, s[7:0]} :
           funct3 == F3_LH  ? {{16{s[15]}}, s[15:0]} :
           funct3 == F3_LBU ? {24'b0, s[7:0]} :
           funct3 == F3_LHU ? {16'b0, s[15:0]} : s;
  end
endmodule

// File: rtl/wb_stage_ctrl.sv
// wb_stage_ctrl: registered RV32I writeback stage with variable-latency load wait,
// flush and load timeout.
module wb_stage_ctrl
  import wb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SRC_W   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m_valid_i,
  output logic             m_ready_o,
  input  logic             m_reg_write_i,
  input  logic [4:0]       m_rd_i,
  input  logic [SRC_W-1:0] m_result_src_i,
  input  logic [XLEN-1:0]  m_alu_result_i,
  input  logic [XLEN-1:0]  m_pc_plus4_i,
  input  logic [XLEN-1:0]  m_imm_i,
  input  logic [2:0]       m_funct3_i,
  input  logic             mem_rvalid_i,
  input  logic [XLEN-1:0]  mem_rdata_i,
  input  logic             flush_i,
  output logic             rf_we_o,
  output logic [4:0]       rf_rd_o,
  output logic [XLEN-1:0]  rf_wdata_o,
  output logic             load_timeout_o,
  output logic             err_o
);
  localparam int CW = $clog2(TIMEOUT);
  wb_state_e state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [4:0] ld_rd, rd_nx;
  logic ld_we;
  logic [2:0] ld_f3;
  logic [1:0] ld_off;
  logic we_nx, to_nx, err_nx, accept, is_load, ext_ill;
  logic [XLEN-1:0] wdata_nx;
  logic [31:0] ext_data;

  load_extend u_ext (
    .funct3(ld_f3), .offset(ld_off), .word(mem_rdata_i[31:0]),
    .data(ext_data), .illegal(ext_ill)
  );

  assign m_ready_o = state == IDLE;
  assign accept = m_valid_i && m_ready_o && !flush_i;
  assign is_load = m_result_src_i == SRC_W'(SRC_LOAD);

  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    we_nx = 1'b0;
    rd_nx = rf_rd_o;
    wdata_nx = rf_wdata_o;
    to_nx = 1'b0;
    err_nx = 1'b0;
    case (state)
      IDLE: begin
        err_nx = mem_rvalid_i;
        if (accept && is_load) begin
          state_nx = WAIT_LOAD;
          cnt_nx = '0;
        end else if (accept) begin
          we_nx = m_reg_write_i && m_rd_i != 5'd0;
          rd_nx = m_rd_i;
          wdata_nx = m_result_src_i == SRC_W'(SRC_PC4) ? m_pc_plus4_i :
                     m_result_src_i == SRC_W'(SRC_IMM) ? m_imm_i : m_alu_result_i;
        end
      end
      WAIT_LOAD: begin
        cnt_nx = cnt + 1'b1;
        // A response consumes the load even when flushed, so no drain is needed.
        if (mem_rvalid_i) begin
          state_nx = IDLE;
          if (!flush_i) begin
            we_nx = ld_we && ld_rd != 5'd0;
            rd_nx = ld_rd;
            wdata_nx = XLEN'(ext_data);
            err_nx = ext_ill;
          end
        end else if (flush_i) begin
          state_nx = DRAIN;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_nx = DRAIN;
          to_nx = 1'b1;
        end
      end
      DRAIN: state_nx = mem_rvalid_i ? IDLE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      ld_rd <= '0;
      ld_we <= 1'b0;
      ld_f3 <= '0;
      ld_off <= '0;
      rf_we_o <= 1'b0;
      rf_rd_o <= '0;
      rf_wdata_o <= '0;
      load_timeout_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (accept && is_load) begin
        ld_rd <= m_rd_i;
        ld_we <= m_reg_write_i;
        ld_f3 <= m_funct3_i;
        ld_off <= m_alu_result_i[1:0];
      end
      rf_we_o <= we_nx;
      rf_rd_o <= rd_nx;
      rf_wdata_o <= wdata_nx;
      load_timeout_o <= to_nx;
      err_o <= err_nx;
    end
  end
endmodule
